// File: rtl/div_oned_seq_if.sv
// Operand/result handshake bundle for the lane-wise Q8.8 divider.
// master = upstream/downstream driver side, slave = the divider.
interface div_oned_seq_if #(
  parameter int LANES = 4,
  parameter int W     = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*W-1:0]   a;
  logic [LANES*W-1:0]   b;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   y;
  logic [LANES-1:0]     dz;
  logic [LANES-1:0]     ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, dz, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, dz, ovf
  );
endinterface

// File: rtl/div_oned_seq.sv
// Lane-parallel restoring divider y_i = (a_i << FRAC) / b_i; result valid W+FRAC clocks after accept.
// Single operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module div_oned_seq #(
  parameter int LANES = 4,
  parameter int W     = 16,
  parameter int FRAC  = 8
) (
  input  logic           clk,
  input  logic           rst,
  div_oned_seq_if.slave  bus
);
  localparam int N  = W + FRAC;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t r_state, w_state_nxt;
  logic [CW-1:0]               r_cnt;
  logic [LANES-1:0][N-1:0]     r_dvd;
  logic [LANES-1:0][N-1:0]     r_q;
  logic [LANES-1:0][W-1:0]     r_rem;
  logic [LANES-1:0][W-1:0]     r_b;
  logic [LANES-1:0][W-1:0]     r_y;
  logic [LANES-1:0]            r_dz;
  logic [LANES-1:0]            r_ovf;

  logic [LANES-1:0][W:0]       w_sh;
  logic [LANES-1:0][W-1:0]     w_diff;
  logic [LANES-1:0][W-1:0]     w_rem_nxt;
  logic [LANES-1:0][N-1:0]     w_q_nxt;
  logic [LANES-1:0][W-1:0]     w_y_nxt;
  logic [LANES-1:0]            w_ge;
  logic [LANES-1:0]            w_bz;
  logic [LANES-1:0]            w_sat;
  logic                        w_accept;
  logic                        w_last;

  assign w_accept      = bus.in_valid && (r_state == IDLE);
  assign w_last        = (r_state == CALC) && (r_cnt == CW'(N - 1));
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_state_nxt = CALC;
      CALC:    if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Lane 0 sits in the MSBs of every packed bus; internal arrays are indexed by lane number.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_sh[i]      = {r_rem[i], r_dvd[i][N-1]};
    assign w_ge[i]      = (w_sh[i] >= {1'b0, r_b[i]});
    // When w_ge is set the true difference is below b, so W bits hold it exactly.
    assign w_diff[i]    = w_sh[i][W-1:0] - r_b[i];
    assign w_rem_nxt[i] = w_ge[i] ? w_diff[i] : w_sh[i][W-1:0];
    assign w_q_nxt[i]   = {r_q[i][N-2:0], w_ge[i]};
    assign w_bz[i]      = (r_b[i] == '0);
    assign w_sat[i]     = |w_q_nxt[i][N-1:W];
    assign w_y_nxt[i]   = (w_bz[i] || w_sat[i]) ? '1 : w_q_nxt[i][W-1:0];

    assign bus.y[(LANES-1-i)*W +: W] = r_y[i];
    assign bus.dz[LANES-1-i]         = r_dz[i];
    assign bus.ovf[LANES-1-i]        = r_ovf[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dvd <= '0;
      r_q   <= '0;
      r_rem <= '0;
      r_b   <= '0;
      r_y   <= '0;
      r_dz  <= '0;
      r_ovf <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
              r_dvd[i] <= {bus.a[(LANES-1-i)*W +: W], {FRAC{1'b0}}};
              r_b[i]   <= bus.b[(LANES-1-i)*W +: W];
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CW'(1);
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          for (int i = 0; i < LANES; i++) begin
            r_dvd[i] <= {r_dvd[i][N-2:0], 1'b0};
          end
          if (w_last) begin
            r_y   <= w_y_nxt;
            r_dz  <= w_bz;
            r_ovf <= w_sat & ~w_bz;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
